bus_mux_pipe: RTL
=================

Name: bus_mux_pipe

Overview:
- Parametrised, registered successor to the processor's combinational bus multiplexer.
- Selects one of NUM_SRC register/memory sources onto the shared core bus through a 1..3-stage pipeline.
- Adds valid/stall handshake, idle hold/zero mode, sticky illegal-select detection and a transfer counter.
- Sits between the control unit's bus-select output and every bus consumer in each core.

Parameters:
REG_WIDTH, 12, bus and source data width
INS_WIDTH, 8, width of the instruction-register source (zero-extended onto bus)
NUM_SRC, 9, number of selectable sources (codes 0..NUM_SRC-1)
SEL_WIDTH, 4, select code width; NUM_SRC+1 <= 2**SEL_WIDTH
INS_IDX, 2, source index carrying the INS_WIDTH instruction value
IDLE_SEL, 9, select code meaning "no driver"; must be >= NUM_SRC
PIPE_STAGES, 1, output latency in cycles, legal 1..3
IDLE_HOLD, 1, 1 = busOut holds last valid data on bubbles, 0 = busOut drives zero
CNT_WIDTH, 16, width of transfer counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
selectIn  in  SEL_WIDTH  source select code
sel_valid  in  1  selectIn is meaningful this cycle
sel_ready  out  1  = ~stall; select accepted when sel_valid & sel_ready
stall  in  1  freeze pipeline (consumer back-pressure)
srcIn  in  NUM_SRC*REG_WIDTH  packed sources, source i at [i*REG_WIDTH +: REG_WIDTH]; at INS_IDX only low INS_WIDTH bits used
busOut  out  REG_WIDTH  registered bus value
bus_valid  out  1  busOut carries a newly delivered transfer this cycle
sel_err  out  1  sticky: illegal select code was accepted
err_sel  out  SEL_WIDTH  first illegal code captured since last clear
err_clr  in  1  clears sel_err and err_sel
xfer_cnt  out  CNT_WIDTH  count of valid transfers delivered, wraps

Behaviour:
- Reset (rst=1 at posedge): all pipeline stages invalid, busOut=0, bus_valid=0, sel_err=0, err_sel=0, xfer_cnt=0. Reset mid-transfer flushes every stage; no data emerges after reset.
- Acceptance at cycle t: sel_valid=1, stall=0.
- Code s < NUM_SRC: source s sampled at cycle t. Source INS_IDX is zero-extended from INS_WIDTH. Enters stage 1 as valid.
- Code == IDLE_SEL, or sel_valid=0: bubble enters stage 1.
- Any other code: bubble enters, sel_err<=1. err_sel<=code only if sel_err was 0 (first error kept).
- Latency: data accepted at cycle t is on busOut with bus_valid=1 after PIPE_STAGES rising edges, for exactly one cycle (absent stall).
- Bubble at output: bus_valid=0. busOut holds previous value if IDLE_HOLD=1, else 0.
- stall=1: all stages, busOut, bus_valid and xfer_cnt frozen. sel_ready=0; selectIn is ignored and no error is flagged. bus_valid stays at its frozen value, and consumers ignore it while stall=1.
- xfer_cnt increments by 1 per cycle with bus_valid=1 and stall=0; wraps 2**CNT_WIDTH-1 -> 0.
- err_clr=1 clears sel_err/err_sel next edge. If a new illegal code is accepted in the same cycle, the new error wins: sel_err=1, err_sel=new code.
- Back-to-back accepts give one transfer per cycle, no gaps.

Decomposition:
- Shared package bus_pkg: select-code localparams (DMem_sel=0, R_sel=1, IR_sel=2, RL_sel=3, RC_sel=4, RP_sel=5, RQ_sel=6, R1_sel=7, AC_sel=8, idle=9), REG_WIDTH/INS_WIDTH defaults.
- One sub-module bus_pipe_stage holds {valid, data} with stall-enable, instantiated PIPE_STAGES times via generate.
- Source-select logic, error logic and counter stay in the top.

Test Plan:
- Reset, src[i]=20+i, PIPE_STAGES=1: accept code 1 -> next cycle busOut=21, bus_valid=1, xfer_cnt=1.
- Back-to-back codes 3,5,6,2 (src[2]=0x1C, 8-bit), PIPE_STAGES=2 -> busOut 23,25,26,28 on consecutive cycles starting 2 cycles after first accept; xfer_cnt=4.
- Accept code 4 then code 9, IDLE_HOLD=1 -> busOut stays 24, bus_valid=0. Repeat with IDLE_HOLD=0 -> busOut=0.
- Accept code 12 then code 14 -> sel_err=1, err_sel=12, no transfer. err_clr together with an accepted code 13 -> sel_err=1, err_sel=13.
- Accept code 7, stall=1 for 3 cycles with selectIn=0 -> outputs frozen, sel_ready=0. Then release -> busOut=27 once, code 0 never delivered.
- Fill pipeline (PIPE_STAGES=3), assert rst -> busOut=0, bus_valid=0 and no further transfers. Force xfer_cnt=0xFFFF, deliver 1 transfer -> xfer_cnt=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus select codes and default widths for the registered core bus multiplexer.
package bus_pkg;

  localparam int BUS_REG_WIDTH = 12;
  localparam int BUS_INS_WIDTH = 8;
  localparam int BUS_NUM_SRC   = 9;
  localparam int BUS_SEL_WIDTH = 4;

  localparam logic [BUS_SEL_WIDTH-1:0] DMem_sel = 4'd0;
  localparam logic [BUS_SEL_WIDTH-1:0] R_sel    = 4'd1;
  localparam logic [BUS_SEL_WIDTH-1:0] IR_sel   = 4'd2;
  localparam logic [BUS_SEL_WIDTH-1:0] RL_sel   = 4'd3;
  localparam logic [BUS_SEL_WIDTH-1:0] RC_sel   = 4'd4;
  localparam logic [BUS_SEL_WIDTH-1:0] RP_sel   = 4'd5;
  localparam logic [BUS_SEL_WIDTH-1:0] RQ_sel   = 4'd6;
  localparam logic [BUS_SEL_WIDTH-1:0] R1_sel   = 4'd7;
  localparam logic [BUS_SEL_WIDTH-1:0] AC_sel   = 4'd8;
  localparam logic [BUS_SEL_WIDTH-1:0] idle     = 4'd9;

endpackage

// File: rtl/bus_pipe_stage.sv
// One {valid, data} pipeline register with stall enable; bubbles either keep or zero the data.
module bus_pipe_stage
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_REG_WIDTH,
  parameter bit HOLD  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end else if (!HOLD) begin
        out_data <= '0;
      end
    end
  end

endmodule

// File: rtl/bus_mux_pipe.sv
// Registered core bus multiplexer: selects one of NUM_SRC sources through a 1..3 stage pipeline
// with valid/stall handshake, sticky illegal-select capture and a delivered-transfer counter.
module bus_mux_pipe
  import bus_pkg::*;
#(
  parameter int REG_WIDTH   = BUS_REG_WIDTH,
  parameter int INS_WIDTH   = BUS_INS_WIDTH,
  parameter int NUM_SRC     = BUS_NUM_SRC,
  parameter int SEL_WIDTH   = BUS_SEL_WIDTH,
  parameter int INS_IDX     = int'(IR_sel),
  parameter int IDLE_SEL    = int'(idle),
  parameter int PIPE_STAGES = 1,
  parameter bit IDLE_HOLD   = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_WIDTH-1:0]         selectIn,
  input  logic                         sel_valid,
  output logic                         sel_ready,
  input  logic                         stall,
  input  logic [NUM_SRC*REG_WIDTH-1:0] srcIn,
  output logic [REG_WIDTH-1:0]         busOut,
  output logic                         bus_valid,
  output logic                         sel_err,
  output logic [SEL_WIDTH-1:0]         err_sel,
  input  logic                         err_clr,
  output logic [CNT_WIDTH-1:0]         xfer_cnt
);

  logic                                accept;
  logic                                code_legal;
  logic                                code_illegal;
  logic                                advance;
  logic [REG_WIDTH-1:0]                src_data;
  logic [PIPE_STAGES:0]                stage_valid;
  logic [PIPE_STAGES:0][REG_WIDTH-1:0] stage_data;

  assign advance      = ~stall;
  assign sel_ready    = advance;
  assign accept       = sel_valid & advance;
  assign code_legal   = int'(selectIn) < NUM_SRC;
  assign code_illegal = accept & ~code_legal & (int'(selectIn) != IDLE_SEL);

  // The instruction-register source only carries INS_WIDTH bits; the rest of its slice is ignored.
  always_comb begin
    src_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(selectIn) == i) begin
        if (i == INS_IDX) begin
          src_data = REG_WIDTH'(srcIn[i*REG_WIDTH +: INS_WIDTH]);
        end else begin
          src_data = srcIn[i*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
  end

  if (REG_WIDTH > INS_WIDTH) begin : g_ins_hi
    logic ins_hi_unused;
    assign ins_hi_unused = ^srcIn[INS_IDX*REG_WIDTH+INS_WIDTH +: REG_WIDTH-INS_WIDTH];
  end

  assign stage_valid[0] = accept & code_legal;
  assign stage_data[0]  = src_data;

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    bus_pipe_stage #(
      .WIDTH(REG_WIDTH),
      .HOLD (IDLE_HOLD)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (advance),
      .in_valid (stage_valid[g]),
      .in_data  (stage_data[g]),
      .out_valid(stage_valid[g+1]),
      .out_data (stage_data[g+1])
    );
  end

  assign busOut    = stage_data[PIPE_STAGES];
  assign bus_valid = stage_valid[PIPE_STAGES];

  // Counts on the edge that loads a valid word into the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (advance && stage_valid[PIPE_STAGES-1]) begin
      xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
    end
  end

  // A new illegal code beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
      err_sel <= '0;
    end else if (code_illegal) begin
      sel_err <= 1'b1;
      if (!sel_err || err_clr) begin
        err_sel <= selectIn;
      end
    end else if (err_clr) begin
      sel_err <= 1'b0;
      err_sel <= '0;
    end
  end

endmodule
